led_pattern_gen: RTL and testbench



---
 rtl/led_pkg.sv | 20 ++
 rtl/led_channel.sv | 87 ++++++++
 rtl/led_pattern_gen.sv | 77 +++++++
 tb/tb_led_pattern_gen.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator: channel mode encodings,
// default clock rates and the prescaler width helper.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_DIM   = 2'd3
    } mode_e;

    localparam int unsigned DEFAULT_CLK_HZ  = 12_000_000;
    localparam int unsigned DEFAULT_TICK_HZ = 1000;

    // A divide-by-1 prescaler still needs a 1-bit register to stay legal.
    function automatic int unsigned prescale_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: configuration registers, blink tick counter and phase,
// and the registered output mux for OFF/ON/BLINK/DIM.
module led_channel
    import led_pkg::*;
#(
    parameter int unsigned PER_W = 16,
    parameter int unsigned PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             wr,
    input  logic [1:0]       cfg_mode,
    input  logic [PER_W-1:0] cfg_period,
    input  logic [PWM_W-1:0] cfg_duty,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic             led
);

    mode_e             mode_q, mode_d;
    logic [PER_W-1:0]  period_q, period_d;
    logic [PWM_W-1:0]  duty_q, duty_d;
    logic [PER_W-1:0]  cnt_q, cnt_d;
    logic              phase_q, phase_d;
    logic              led_q, led_d;
    logic              blink_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= MODE_OFF;
            period_q <= '0;
            duty_q   <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            led_q    <= led_d;
        end
    end

    // Period 0 is treated as period 1: every tick is the last one.
    assign blink_last = (period_q == '0) || (cnt_q >= period_q - 1'b1);

    always_comb begin
        mode_d   = mode_q;
        period_d = period_q;
        duty_d   = duty_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        if (wr) begin
            // A write wins over a coincident tick: restart without toggling.
            mode_d   = mode_e'(cfg_mode);
            period_d = cfg_period;
            duty_d   = cfg_duty;
            cnt_d    = '0;
            phase_d  = 1'b1;
        end else if (mode_q != MODE_BLINK) begin
            cnt_d = '0;
        end else if (tick) begin
            if (blink_last) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        led_d = 1'b0;
        case (mode_q)
            MODE_OFF:   led_d = 1'b0;
            MODE_ON:    led_d = 1'b1;
            MODE_BLINK: led_d = phase_q;
            MODE_DIM:   led_d = (pwm_cnt < duty_q);
            default:    led_d = 1'b0;
        endcase
    end

    assign led = led_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared tick prescaler and PWM counter,
// configuration write decode with bad-channel error pulse, per-channel logic.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int unsigned CLK_HZ  = DEFAULT_CLK_HZ,
    parameter int unsigned TICK_HZ = DEFAULT_TICK_HZ,
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned PER_W   = 16,
    parameter int unsigned PWM_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [PER_W-1:0]  cfg_period,
    input  logic [PWM_W-1:0]  cfg_duty,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] led
);

    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned PRE_W = prescale_width(DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PWM_W-1:0] pwm_q, pwm_d;
    logic             err_q, err_d;
    logic             tick;
    logic             wr_en;
    logic             bad_ch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            pwm_q <= '0;
            err_q <= 1'b0;
        end else begin
            pre_q <= pre_d;
            pwm_q <= pwm_d;
            err_q <= err_d;
        end
    end

    assign cfg_ready = ~rst;
    assign wr_en     = cfg_valid & cfg_ready;
    assign bad_ch    = {1'b0, cfg_ch} >= 5'(NUM_CH);
    assign tick      = (pre_q == PRE_MAX);

    always_comb begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        pwm_d = pwm_q + 1'b1;
        err_d = wr_en & bad_ch;
    end

    assign cfg_err = err_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_channel #(
            .PER_W(PER_W),
            .PWM_W(PWM_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .wr        (wr_en && (cfg_ch == 4'(i))),
            .cfg_mode  (cfg_mode),
            .cfg_period(cfg_period),
            .cfg_duty  (cfg_duty),
            .pwm_cnt   (pwm_q),
            .led       (led[i])
        );
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen with a tick-count based reference model.
module tb_led_pattern_gen;

    localparam int unsigned CLK_HZ  = 1000;
    localparam int unsigned TICK_HZ = 100;
    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned PER_W   = 16;
    localparam int unsigned PWM_W   = 4;
    localparam int          DIV     = 10;
    localparam int          PWM_N   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [3:0]        cfg_ch = '0;
    logic [1:0]        cfg_mode = '0;
    logic [PER_W-1:0]  cfg_period = '0;
    logic [PWM_W-1:0]  cfg_duty = '0;
    logic              cfg_err;
    logic [NUM_CH-1:0] led;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: config per channel plus ticks seen since the last write.
    int edge_n;
    int m_mode  [NUM_CH];
    int m_per   [NUM_CH];
    int m_duty  [NUM_CH];
    int m_ticks [NUM_CH];
    logic [NUM_CH-1:0] exp_led;
    logic              exp_err;

    led_pattern_gen #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ),
        .NUM_CH (NUM_CH),
        .PER_W  (PER_W),
        .PWM_W  (PWM_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_mode  (cfg_mode),
        .cfg_period(cfg_period),
        .cfg_duty  (cfg_duty),
        .cfg_err   (cfg_err),
        .led       (led)
    );

    always #5 clk = ~clk;

    function automatic logic model_led(input int c, input int pwm);
        int eff;
        case (m_mode[c])
            1: return 1'b1;
            2: begin
                eff = (m_per[c] == 0) ? 1 : m_per[c];
                return ((m_ticks[c] / eff) % 2) == 0;
            end
            3: return pwm < m_duty[c];
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_clear();
        edge_n = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_mode[c] = 0; m_per[c] = 0; m_duty[c] = 0; m_ticks[c] = 0;
        end
        exp_led = '0;
        exp_err = 1'b0;
    endtask

    // One clock: drive inputs, take the edge, advance the model, settle 1 time unit.
    task automatic step(input logic v, input int ch, input int mode, input int per,
                        input int duty);
        logic tk;
        cfg_valid  = v;
        cfg_ch     = 4'(ch);
        cfg_mode   = 2'(mode);
        cfg_period = PER_W'(per);
        cfg_duty   = PWM_W'(duty);
        @(posedge clk);
        edge_n++;
        tk = (edge_n % DIV) == 0;
        for (int c = 0; c < NUM_CH; c++) exp_led[c] = model_led(c, (edge_n - 1) % PWM_N);
        exp_err = v && (ch >= NUM_CH);
        for (int c = 0; c < NUM_CH; c++) begin
            if (v && ch == c) begin
                m_mode[c] = mode; m_per[c] = per; m_duty[c] = duty; m_ticks[c] = 0;
            end else if (m_mode[c] != 2) begin
                m_ticks[c] = 0;
            end else if (tk) begin
                m_ticks[c]++;
            end
        end
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_tests++;
        if (led !== '0 || cfg_ready !== 1'b0 || cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_assert: led=%b ready=%b err=%b, want 0/0/0", led, cfg_ready,
                     cfg_err);
        end
        repeat (3) @(posedge clk);
        #4;
        rst = 1'b0;
        model_clear();
        for (int k = 0; k < 15; k++) begin
            step(1'b0, 0, 0, 0, 0);
            n_tests++;
            if (led !== '0 || cfg_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_release: led=%b ready=%b, want 0000/1", led, cfg_ready);
            end
        end
    endtask

    task automatic test_blink();
        int last_t;
        logic prev;
        step(1'b1, 1, 2, 3, 0);
        step(1'b0, 0, 0, 0, 0);
        n_tests++;
        if (led !== 4'b0010) begin
            n_fail++;
            $display("FAIL blink_start: led=%b, want 0010", led);
        end
        prev = led[1];
        last_t = edge_n;
        for (int k = 0; k < 100; k++) begin
            step(1'b0, 0, 0, 0, 0);
            n_tests++;
            if (led !== exp_led) begin
                n_fail++;
                $display("FAIL blink_model: led=%b, want %b", led, exp_led);
            end
            if (led[1] !== prev) begin
                n_tests++;
                if (k > 30 && (edge_n - last_t) != 30) begin
                    n_fail++;
                    $display("FAIL blink_interval: got %0d clk, want 30", edge_n - last_t);
                end
                last_t = edge_n;
                prev = led[1];
            end
        end
    endtask

    task automatic test_dim();
        int duties [3] = '{5, 0, 15};
        int highs;
        foreach (duties[d]) begin
            step(1'b1, 2, 3, 0, duties[d]);
            step(1'b0, 0, 0, 0, 0);
            highs = 0;
            for (int k = 0; k < 32; k++) begin
                step(1'b0, 0, 0, 0, 0);
                if (led[2]) highs++;
                n_tests++;
                if (led !== exp_led) begin
                    n_fail++;
                    $display("FAIL dim_model: led=%b, want %b", led, exp_led);
                end
            end
            n_tests++;
            if (highs != 2 * duties[d]) begin
                n_fail++;
                $display("FAIL dim_count duty=%0d: high %0d of 32, want %0d", duties[d], highs,
                         2 * duties[d]);
            end
        end
    endtask

    task automatic test_bad_ch();
        int bad [2];
        bad[0] = 7;
        bad[1] = int'($urandom_range(15, 4));
        foreach (bad[b]) begin
            step(1'b1, bad[b], 1, 5, 9);
            n_tests++;
            if (cfg_err !== 1'b1 || led !== exp_led) begin
                n_fail++;
                $display("FAIL bad_ch_err ch=%0d: err=%b led=%b, want 1 %b", bad[b], cfg_err,
                         led, exp_led);
            end
            for (int k = 0; k < 25; k++) begin
                step(1'b0, 0, 0, 0, 0);
                n_tests++;
                if (cfg_err !== 1'b0 || led !== exp_led) begin
                    n_fail++;
                    $display("FAIL bad_ch_after: err=%b led=%b, want 0 %b", cfg_err, led,
                             exp_led);
                end
            end
        end
    endtask

    task automatic test_collision();
        int guard;
        step(1'b1, 0, 2, 2, 0);
        guard = 0;
        // Advance until the next edge is a tick that would toggle ch0.
        while (!(((edge_n + 1) % DIV == 0) && (m_ticks[0] % 2 == 1)) && guard < 200) begin
            step(1'b0, 0, 0, 0, 0);
            guard++;
        end
        n_tests++;
        if (guard >= 200) begin
            n_fail++;
            $display("FAIL collision_setup: no terminal tick within %0d clk, want one", guard);
        end
        step(1'b1, 0, 2, 2, 0);
        for (int k = 1; k <= 21; k++) begin
            step(1'b0, 0, 0, 0, 0);
            n_tests++;
            if (led[0] !== (k <= 20)) begin
                n_fail++;
                $display("FAIL collision_phase k=%0d: led0=%b, want %b", k, led[0], k <= 20);
            end
        end
    endtask

    task automatic test_period0();
        int last_t;
        int n_tog;
        logic prev;
        step(1'b1, 3, 2, 0, 0);
        step(1'b0, 0, 0, 0, 0);
        prev = led[3];
        last_t = edge_n;
        n_tog = 0;
        for (int k = 0; k < 60; k++) begin
            step(1'b0, 0, 0, 0, 0);
            n_tests++;
            if (led !== exp_led) begin
                n_fail++;
                $display("FAIL period0_model: led=%b, want %b", led, exp_led);
            end
            if (led[3] !== prev) begin
                if (n_tog > 0) begin
                    n_tests++;
                    if (edge_n - last_t != DIV) begin
                        n_fail++;
                        $display("FAIL period0_interval: got %0d clk, want %0d",
                                 edge_n - last_t, DIV);
                    end
                end
                n_tog++;
                last_t = edge_n;
                prev = led[3];
            end
        end
    endtask

    task automatic test_random();
        logic v;
        for (int k = 0; k < 400; k++) begin
            v = ($urandom_range(3, 0) == 0);
            step(v, int'($urandom_range(7, 0)), int'($urandom_range(3, 0)),
                 int'($urandom_range(4, 0)), int'($urandom_range(15, 0)));
            n_tests++;
            if (led !== exp_led || cfg_err !== exp_err) begin
                n_fail++;
                $display("FAIL random k=%0d: led=%b err=%b, want %b %b", k, led, cfg_err,
                         exp_led, exp_err);
            end
        end
    endtask

    initial begin
        model_clear();
        @(posedge clk);
        #1;
        test_reset();
        test_blink();
        test_dim();
        test_bad_ch();
        test_collision();
        test_period0();
        test_reset();
        test_random();
        step(1'b1, 1, 2, 1, 0);
        repeat (7) step(1'b0, 0, 0, 0, 0);
        test_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
